sort_engine_ctrl: RTL and testbench
===================================

Name: sort_engine_ctrl

Overview:
Sequencer for the comparison-free sorting engine. It collects ELEMENT_NUM unsorted elements over a valid/ready input stream into an internal unsorted-memory register file and drives it flat onto the engine. It then raises the engine's flag for exactly ELEMENT_NUM cycles and records the engine's largest-element address each cycle. Finally it streams the elements back in sorted order over a valid/ready output stream. It sits between the upstream data source and the engine, and is the only driver of the engine's flag and UM_data inputs.

Parameters:
ELEMENT_NUM, 8, number of elements per sort batch (matches the engine build).
DATA_WIDTH, 8, bits per element.
LOG2_ELEMENT_NUM, 3, address width; equals ceil(log2(ELEMENT_NUM)).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous reset, active-high.
in_valid  in  1  upstream element valid.
in_data  in  DATA_WIDTH  upstream element.
in_ready  out  1  controller accepts in_data this cycle.
out_valid  out  1  sorted element valid.
out_data  out  DATA_WIDTH  sorted element value.
out_idx  out  LOG2_ELEMENT_NUM  original load position of out_data.
out_last  out  1  marks the final element of the batch.
out_ready  in  1  downstream accepts this cycle.
busy  out  1  high in SORT and DRAIN.
se_flag  out  1  to the engine's flag input; registered.
se_um_data  out  ELEMENT_NUM*DATA_WIDTH  to the engine's UM_data input. Element i sits at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
se_le_addr  in  LOG2_ELEMENT_NUM  from the engine's LE_Addr output.

Behaviour:
- Reset (async, any state): state=LOAD, wr_cnt=0, sort_cnt=0, rd_cnt=0, se_flag=0, in_ready=1, out_valid=0, out_last=0, busy=0.
- Reset does not clear the element registers or the index registers, so out_data/out_idx are don't-care while out_valid=0.
- Reset mid-SORT drops se_flag asynchronously. The engine reinitialises its mask on its next clock edge.
- States:
  - LOAD:
    - in_ready=1.
    - On in_valid&in_ready: elem[wr_cnt]<=in_data, wr_cnt++.
    - When the handshake occurs with wr_cnt==ELEMENT_NUM-1: wr_cnt<=0, se_flag<=1, go to SORT.
  - SORT: exactly ELEMENT_NUM cycles.
    - in_ready=0; input is ignored and not consumed.
    - Each cycle: idx[sort_cnt]<=se_le_addr, sort_cnt++.
    - se_le_addr is combinational from the engine's mask, so cycle k of flag-high presents the k-th largest address. The first cycle sees the all-ones mask.
    - At sort_cnt==ELEMENT_NUM-1: se_flag<=0, sort_cnt<=0, go to DRAIN.
  - DRAIN:
    - out_valid=1, out_data=elem[idx[rd_cnt]], out_idx=idx[rd_cnt], out_last=(rd_cnt==ELEMENT_NUM-1).
    - On out_valid&out_ready: rd_cnt++.
    - On the handshake with out_last: rd_cnt<=0, go to LOAD.
- se_flag is low in LOAD and DRAIN. The engine mask is therefore held at all-ones between batches.
- se_um_data is a direct concatenation of elem[]. It is stable throughout SORT because elem is written only in LOAD.
- Backpressure: with out_ready=0, out_valid/out_data/out_idx/out_last hold unchanged.
- Sort order is the engine's: two's-complement signed, largest first.
- Ties: the controller records whatever address the engine presents. It performs no checking.
- Minimum batch latency: ELEMENT_NUM load cycles + ELEMENT_NUM sort cycles + ELEMENT_NUM drain cycles. First out_valid appears the cycle after the last sort cycle.
- Counters saturate only by state transitions. No wrap past ELEMENT_NUM-1 is possible.
- busy = state is SORT or DRAIN.

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, se_flag=0, busy=0. Hold in_valid=0 for 20 cycles → no state change.
- Load 5,200,17,127,0,128,3,64 back-to-back with the real engine attached, out_ready=1:
  - se_flag high exactly 8 cycles, starting the cycle after the 8th handshake.
  - out_data = 127,64,17,5,3,0,200,128.
  - out_idx = 3,7,2,0,6,4,1,5.
  - out_last only on 128.
- Same batch with in_valid toggling 1/0 and out_ready toggling 0/1 every cycle:
  - identical output sequence.
  - out_* stable across every stall.
  - in_ready=0 for the whole of SORT and DRAIN.
- Two batches back-to-back:
  - in_ready rises the cycle after out_last is accepted.
  - The second batch (1..8 ascending) drains as 8,7,6,5,4,3,2,1.
- Assert rst on the 4th SORT cycle:
  - se_flag=0 and out_valid=0 immediately.
  - state=LOAD.
  - A following full batch sorts correctly.
- Assert rst mid-DRAIN with out_ready=0 → out_valid drops asynchronously and no further output appears until a new batch is loaded.

Source files
------------

// File: rtl/sort_engine_ctrl_if.sv
// Stream interface for sort_engine_ctrl.
//   in_valid/in_data/in_ready       : upstream element stream (unsorted)
//   out_valid/out_data/out_idx/
//   out_last/out_ready              : downstream stream (sorted, largest first)
// slave  : controller side (accepts input, produces output)
// master : environment side (produces input, accepts output)
interface sort_engine_ctrl_if #(
  parameter int DATA_WIDTH       = 8,
  parameter int LOG2_ELEMENT_NUM = 3
);
  logic                        in_valid;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        in_ready;
  logic                        out_valid;
  logic [DATA_WIDTH-1:0]       out_data;
  logic [LOG2_ELEMENT_NUM-1:0] out_idx;
  logic                        out_last;
  logic                        out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

// File: rtl/sort_engine_ctrl.sv
// Sequencer for the comparison-free sorting engine.
// Loads ELEMENT_NUM elements from the input stream, presents them flat on
// se_um_data, pulses se_flag for ELEMENT_NUM cycles while recording the
// engine's largest-element address each cycle, then streams the elements
// out in that order.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : input/output streams (sort_engine_ctrl_if.slave)
//   busy        : high while sorting or draining
//   se_flag     : registered flag to the engine
//   se_um_data  : element i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   se_le_addr  : engine's current largest-element address
module sort_engine_ctrl #(
  parameter int ELEMENT_NUM      = 8,
  parameter int DATA_WIDTH       = 8,
  parameter int LOG2_ELEMENT_NUM = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  sort_engine_ctrl_if.slave                 bus,
  output logic                              busy,
  output logic                              se_flag,
  output logic [ELEMENT_NUM*DATA_WIDTH-1:0] se_um_data,
  input  logic [LOG2_ELEMENT_NUM-1:0]       se_le_addr
);

  localparam logic [LOG2_ELEMENT_NUM-1:0] CNT_LAST = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_DRAIN
  } state_t;

  state_t                      state_q, state_d;
  logic [LOG2_ELEMENT_NUM-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2_ELEMENT_NUM-1:0] sort_cnt_q, sort_cnt_d;
  logic [LOG2_ELEMENT_NUM-1:0] rd_cnt_q, rd_cnt_d;
  logic                        se_flag_q, se_flag_d;

  // Data registers carry no reset; their contents are only observed after
  // a full load.
  logic [DATA_WIDTH-1:0]       elem_q [ELEMENT_NUM];
  logic [DATA_WIDTH-1:0]       elem_d [ELEMENT_NUM];
  logic [LOG2_ELEMENT_NUM-1:0] idx_q  [ELEMENT_NUM];
  logic [LOG2_ELEMENT_NUM-1:0] idx_d  [ELEMENT_NUM];

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    sort_cnt_d = sort_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    se_flag_d  = se_flag_q;
    elem_d     = elem_q;
    idx_d      = idx_q;

    case (state_q)
      S_LOAD: begin
        // in_ready is constantly high here, so in_valid alone is the handshake.
        if (bus.in_valid) begin
          elem_d[wr_cnt_q] = bus.in_data;
          if (wr_cnt_q == CNT_LAST) begin
            wr_cnt_d  = '0;
            se_flag_d = 1'b1;
            state_d   = S_SORT;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end

      S_SORT: begin
        // The engine retires one address per flag-high cycle, largest first.
        idx_d[sort_cnt_q] = se_le_addr;
        if (sort_cnt_q == CNT_LAST) begin
          sort_cnt_d = '0;
          se_flag_d  = 1'b0;
          state_d    = S_DRAIN;
        end else begin
          sort_cnt_d = sort_cnt_q + 1'b1;
        end
      end

      S_DRAIN: begin
        if (bus.out_ready) begin
          if (rd_cnt_q == CNT_LAST) begin
            rd_cnt_d = '0;
            state_d  = S_LOAD;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_LOAD;
      wr_cnt_q   <= '0;
      sort_cnt_q <= '0;
      rd_cnt_q   <= '0;
      se_flag_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      sort_cnt_q <= sort_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      se_flag_q  <= se_flag_d;
    end
  end

  always_ff @(posedge clk) begin
    elem_q <= elem_d;
    idx_q  <= idx_d;
  end

  // Stream outputs decode directly from the state register so that an
  // asynchronous reset drops out_valid and raises in_ready immediately.
  always_comb begin
    bus.in_ready  = (state_q == S_LOAD);
    bus.out_valid = (state_q == S_DRAIN);
    bus.out_last  = (state_q == S_DRAIN) && (rd_cnt_q == CNT_LAST);
    bus.out_idx   = idx_q[rd_cnt_q];
    bus.out_data  = elem_q[idx_q[rd_cnt_q]];
    busy          = (state_q == S_SORT) || (state_q == S_DRAIN);
    se_flag       = se_flag_q;
  end

  always_comb begin
    se_um_data = '0;
    for (int unsigned i = 0; i < ELEMENT_NUM; i++) begin
      se_um_data[i*DATA_WIDTH +: DATA_WIDTH] = elem_q[i];
    end
  end

endmodule

// File: tb/tb_sort_engine_ctrl.sv
// Testbench for sort_engine_ctrl with a behavioural sorting-engine model.
module tb_sort_engine_ctrl;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int L  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sort_engine_ctrl_if #(.DATA_WIDTH(DW), .LOG2_ELEMENT_NUM(L)) bus ();

  logic            busy;
  logic            se_flag;
  logic [N*DW-1:0] se_um_data;
  logic [L-1:0]    se_le_addr;

  sort_engine_ctrl #(
    .ELEMENT_NUM(N),
    .DATA_WIDTH(DW),
    .LOG2_ELEMENT_NUM(L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .se_flag   (se_flag),
    .se_um_data(se_um_data),
    .se_le_addr(se_le_addr)
  );

  // Engine model: mask held all-ones while flag low; while flag high the
  // unmasked signed maximum (lowest index on ties) is presented and retired.
  logic [N-1:0]          mask;
  logic                  found;
  logic signed [DW-1:0]  best;

  always_ff @(posedge clk) begin
    if (!se_flag) mask <= '1;
    else          mask[se_le_addr] <= 1'b0;
  end

  always_comb begin
    se_le_addr = '0;
    found      = 1'b0;
    best       = '0;
    for (int i = 0; i < N; i++) begin
      if (mask[i] && (!found || $signed(se_um_data[i*DW +: DW]) > best)) begin
        found      = 1'b1;
        best       = $signed(se_um_data[i*DW +: DW]);
        se_le_addr = L'(i);
      end
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [DW-1:0] data;
    logic [L-1:0]  idx;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   out_mode = 0;  // 0: ready, 1: toggle, 2: stalled, 3: random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: an element's output position is the number of elements that
  // outrank it (larger signed value, or equal value at a lower load index).
  task automatic push_expected(input logic [DW-1:0] v [N]);
    exp_t sorted [N];
    for (int i = 0; i < N; i++) begin
      int rank = 0;
      for (int j = 0; j < N; j++) begin
        if ($signed(v[j]) > $signed(v[i]) || (v[j] == v[i] && j < i)) rank++;
      end
      sorted[rank].data = v[i];
      sorted[rank].idx  = L'(i);
      sorted[rank].last = (rank == N - 1);
    end
    for (int r = 0; r < N; r++) exp_q.push_back(sorted[r]);
  endtask

  // Call at posedge+#1; returns at posedge+#1 after the last accepting edge.
  task automatic load_batch(input logic [DW-1:0] v [N], input int gap_mode);
    int   k = 0;
    int   budget = 0;
    logic tog = 1'b1;
    logic acc;
    logic [N*DW-1:0] um;
    while (k < N && budget < 400) begin
      case (gap_mode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = tog;
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      bus.in_data = v[k];
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready && !rst;
      @(posedge clk);
      #1;
      if (acc) k++;
      budget++;
    end
    bus.in_valid = 1'b0;
    check("load_complete", 64'(k), 64'(N));
    if (k == N) begin
      for (int i = 0; i < N; i++) um[i*DW +: DW] = v[i];
      check("flag_starts_after_last_load", 64'(se_flag), 64'd1);
      check("se_um_data", 64'(se_um_data), 64'(um));
      push_expected(v);
    end
  endtask

  task automatic wait_drain();
    int budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < 600) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (out_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  initial begin
    exp_t held;
    exp_t e;
    logic held_valid = 1'b0;
    logic expect_ready = 1'b0;
    int   flag_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        flag_run     = 0;
        held_valid   = 1'b0;
        expect_ready = 1'b0;
      end else begin
        if (expect_ready) begin
          check("in_ready_after_last", 64'(bus.in_ready), 64'd1);
          expect_ready = 1'b0;
        end
        if (se_flag) begin
          flag_run++;
          check("in_ready_low_in_sort", 64'(bus.in_ready), 64'd0);
        end else if (flag_run != 0) begin
          check("flag_length", 64'(flag_run), 64'(N));
          flag_run = 0;
        end
        if (held_valid) begin
          check("valid_held_in_stall", 64'(bus.out_valid), 64'd1);
          if (bus.out_valid) begin
            check("data_stable", 64'(bus.out_data), 64'(held.data));
            check("idx_stable", 64'(bus.out_idx), 64'(held.idx));
            check("last_stable", 64'(bus.out_last), 64'(held.last));
          end
          held_valid = 1'b0;
        end
        if (bus.out_valid) begin
          check("in_ready_low_in_drain", 64'(bus.in_ready), 64'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(bus.out_valid), 64'd0);
          end else if (bus.out_ready) begin
            e = exp_q.pop_front();
            check("out_data", 64'(bus.out_data), 64'(e.data));
            check("out_idx", 64'(bus.out_idx), 64'(e.idx));
            check("out_last", 64'(bus.out_last), 64'(e.last));
            if (e.last) expect_ready = 1'b1;
          end else begin
            held_valid = 1'b1;
            held.data  = bus.out_data;
            held.idx   = bus.out_idx;
            held.last  = bus.out_last;
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Main sequence
  initial begin
    logic [DW-1:0] b [N];
    int budget;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    check("rst_se_flag", 64'(se_flag), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle with in_valid low
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("idle_in_ready", 64'(bus.in_ready), 64'd1);
      check("idle_out_valid", 64'(bus.out_valid), 64'd0);
      check("idle_se_flag", 64'(se_flag), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end

    // Directed batch, back-to-back, always ready
    b = '{8'd5, 8'd200, 8'd17, 8'd127, 8'd0, 8'd128, 8'd3, 8'd64};
    out_mode = 0;
    load_batch(b, 0);
    wait_drain();

    // Same batch with toggling valid and ready
    out_mode = 1;
    load_batch(b, 1);
    wait_drain();

    // Two batches back-to-back
    out_mode = 0;
    load_batch(b, 0);
    b = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load_batch(b, 0);
    wait_drain();

    // Reset on the 4th SORT cycle
    b = '{8'd9, 8'd250, 8'd33, 8'd100, 8'd7, 8'd129, 8'd77, 8'd1};
    load_batch(b, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("sort_rst_se_flag", 64'(se_flag), 64'd0);
    check("sort_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("sort_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("sort_rst_busy", 64'(busy), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    load_batch(b, 0);
    wait_drain();

    // Reset mid-DRAIN under backpressure
    out_mode = 2;
    b = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    load_batch(b, 0);
    budget = 0;
    while (!bus.out_valid && budget < 40) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("drain_reached", 64'(bus.out_valid), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("drain_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("drain_rst_out_last", 64'(bus.out_last), 64'd0);
    check("drain_rst_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_mode = 0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_no_output", 64'(bus.out_valid), 64'd0);
    load_batch(b, 0);
    wait_drain();

    // Randomised batches, some drawn from a narrow range to force ties
    out_mode = 3;
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) begin
        if (t % 2 == 0) b[i] = DW'($urandom);
        else            b[i] = DW'($urandom_range(0, 3)) - DW'(2);
      end
      load_batch(b, 2);
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
